// File: rtl/adc_sample_fifo_if.sv
// adc_sample_fifo_if: sample stream in, FWFT ready/valid stream out, plus occupancy/overflow status
interface adc_sample_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] level;
    logic                   almost_full;
    logic                   overflow;
    logic                   ovf_clr;

    modport master (
        output in_data, in_valid, out_ready, ovf_clr,
        input  out_data, out_valid, level, almost_full, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready, ovf_clr,
        output out_data, out_valid, level, almost_full, overflow
    );
endinterface

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: FWFT buffer behind the ADC decimator with drop detection; ADC_FIFO_PEAK_EN adds a |sample| peak tracker
module adc_sample_fifo #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input logic                    clk,
    input logic                    rst,
    adc_sample_fifo_if.slave       bus
`ifdef ADC_FIFO_PEAK_EN
    ,
    output logic [WIDTH-2:0]       peak_abs,
    input  logic                   peak_clr
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_nxt;
    logic             out_valid;
    logic             almost_full;
    logic             overflow;
    logic             pop;
    logic             push;
    logic             drop;

    assign pop       = out_valid && bus.out_ready;
    assign push      = bus.in_valid && (level != LW'(DEPTH) || pop);
    assign drop      = bus.in_valid && !push;
    assign level_nxt = (push && !pop) ? level + LW'(1) : (pop && !push) ? level - LW'(1) : level;

    // The head is read straight from memory; gating on out_valid keeps out_data at 0 during and after reset.
    assign bus.out_data    = out_valid ? mem[rd_ptr] : '0;
    assign bus.out_valid   = out_valid;
    assign bus.level       = level;
    assign bus.almost_full = almost_full;
    assign bus.overflow    = overflow;

    // Sample storage; contents need no reset because out_valid masks them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // Pointers, occupancy and status flags; a drop on the same edge as ovf_clr keeps overflow set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
            level       <= level_nxt;
            out_valid   <= level_nxt != '0;
            almost_full <= level_nxt >= LW'(AFULL_LEVEL);
            overflow    <= drop || (overflow && !bus.ovf_clr);
        end
    end

`ifdef ADC_FIFO_PEAK_EN
    logic [WIDTH-1:0] neg_data;
    logic [WIDTH-2:0] mag;

    assign neg_data = -bus.in_data;
    assign mag      = !bus.in_data[WIDTH-1] ? bus.in_data[WIDTH-2:0] : neg_data[WIDTH-1] ? '1 : neg_data[WIDTH-2:0];

    // Running max of |sample| over accepted pushes; a clear with a push restarts from that sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_abs <= '0;
        end else if (push) begin
            peak_abs <= (peak_clr || mag > peak_abs) ? mag : peak_abs;
        end else if (peak_clr) begin
            peak_abs <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: scoreboard bench for adc_sample_fifo; peak checks compile in with ADC_FIFO_PEAK_EN
module tb_adc_sample_fifo;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AF = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    adc_sample_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

`ifdef ADC_FIFO_PEAK_EN
    logic [W-2:0] peak_abs;
    logic         peak_clr = 1'b0;
    adc_sample_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
        .clk(clk), .rst(rst), .bus(bus), .peak_abs(peak_abs), .peak_clr(peak_clr)
    );
`else
    adc_sample_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    // One clock: score the pop that this edge performs, record the accepted push, then clear strobes.
    task automatic tick();
        logic         pop;
        logic [W-1:0] exp;
        pop = bus.out_valid && bus.out_ready;
        if (pop) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: DUT popped %h but no sample expected", bus.out_data);
            end else begin
                exp = sb.pop_front();
                if (bus.out_data !== exp) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected %h", bus.out_data, exp);
                end
            end
        end
        if (bus.in_valid && sb.size() < D) sb.push_back(bus.in_data);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ovf_clr  = 1'b0;
`ifdef ADC_FIFO_PEAK_EN
        peak_clr = 1'b0;
`endif
    endtask

    task automatic push_n(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + W'(i);
            tick();
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < D + 2; i++) tick();
        checks++;
        if (bus.level !== '0 || bus.out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: level=%0d out_valid=%b left=%0d expected 0/0/0", bus.level, bus.out_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr  = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.level !== '0 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h level=%0d af=%b ovf=%b expected all 0",
                     bus.out_valid, bus.out_data, bus.level, bus.almost_full, bus.overflow);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_flow();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234 || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL basic_first: valid=%b data=%h level=%0d expected 1/1234/1", bus.out_valid, bus.out_data, bus.level);
        end
        tick();
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hABCD;
        tick();
        checks++;
        if (bus.out_data !== 16'hABCD) begin
            errors++;
            $display("FAIL basic_second: data=%h expected abcd", bus.out_data);
        end
        tick();
        checks++;
        if (bus.level !== '0 || bus.overflow !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: level=%0d ovf=%b valid=%b expected 0/0/0", bus.level, bus.overflow, bus.out_valid);
        end
    endtask

    task automatic test_fill_drop();
        bus.out_ready = 1'b0;
        for (int i = 0; i <= D; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(i);
            tick();
            if (i == AF - 2) begin
                checks++;
                if (bus.almost_full !== 1'b0) begin
                    errors++;
                    $display("FAIL af_below: almost_full=%b expected 0 at level %0d", bus.almost_full, i + 1);
                end
            end
            if (i == AF - 1) begin
                checks++;
                if (bus.almost_full !== 1'b1 || bus.level !== 5'(AF)) begin
                    errors++;
                    $display("FAIL af_at: af=%b level=%0d expected 1/%0d", bus.almost_full, bus.level, AF);
                end
            end
            if (i == D - 1) begin
                checks++;
                if (bus.overflow !== 1'b0 || bus.level !== 5'(D)) begin
                    errors++;
                    $display("FAIL full_no_drop: ovf=%b level=%0d expected 0/%0d", bus.overflow, bus.level, D);
                end
            end
        end
        checks++;
        if (bus.level !== 5'(D) || bus.overflow !== 1'b1 || bus.out_data !== 16'h0000) begin
            errors++;
            $display("FAIL drop: level=%0d ovf=%b head=%h expected %0d/1/0000", bus.level, bus.overflow, bus.out_data, D);
        end
        drain();
        checks++;
        if (bus.overflow !== 1'b1 || bus.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b af=%b expected 1/0", bus.overflow, bus.almost_full);
        end
        bus.ovf_clr = 1'b1;
        tick();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b expected 0", bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        bus.out_ready = 1'b0;
        push_n(D, 16'h0100);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.level !== 5'(D) || bus.overflow !== 1'b0 || bus.out_data !== 16'h0101) begin
            errors++;
            $display("FAIL full_pushpop: level=%0d ovf=%b head=%h expected %0d/0/0101", bus.level, bus.overflow, bus.out_data, D);
        end
        checks++;
        if (sb.size() != D || sb[D-1] !== 16'h5555) begin
            errors++;
            $display("FAIL full_pushpop_tail: queued=%0d expected %0d with 5555 last", sb.size(), D);
        end
        drain();
    endtask

    task automatic test_ovf_race();
        bus.out_ready = 1'b0;
        push_n(D, 16'h0200);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        bus.ovf_clr  = 1'b1;
        tick();
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_race: ovf=%b expected 1", bus.overflow);
        end
        bus.ovf_clr = 1'b1;
        tick();
        checks++;
        if (bus.overflow !== 1'b0 || bus.level !== 5'(D)) begin
            errors++;
            $display("FAIL ovf_race_clr: ovf=%b level=%0d expected 0/%0d", bus.overflow, bus.level, D);
        end
        drain();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        push_n(7, 16'h0300);
        checks++;
        if (bus.level !== 5'd7) begin
            errors++;
            $display("FAIL pre_reset_level: level=%0d expected 7", bus.level);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.level !== '0 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h level=%0d af=%b ovf=%b expected all 0",
                     bus.out_valid, bus.out_data, bus.level, bus.almost_full, bus.overflow);
        end
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0042;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0042 || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL post_reset: valid=%b data=%h level=%0d expected 1/0042/1", bus.out_valid, bus.out_data, bus.level);
        end
        drain();
    endtask

`ifdef ADC_FIFO_PEAK_EN
    task automatic test_peak();
        logic [W-1:0] din[4];
        logic [W-2:0] exp[4];
        din = '{16'h0100, 16'hFE00, 16'h8000, 16'h0003};
        exp = '{15'h0100, 15'h0200, 15'h7FFF, 15'h0003};
        bus.out_ready = 1'b1;
        peak_clr = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = din[i];
            peak_clr = (i == 3);
            tick();
            checks++;
            if (peak_abs !== exp[i]) begin
                errors++;
                $display("FAIL peak_%0d: peak_abs=%h expected %h", i, peak_abs, exp[i]);
            end
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_flow();
        test_fill_drop();
        test_full_push_pop();
        test_ovf_race();
        test_async_reset();
`ifdef ADC_FIFO_PEAK_EN
        test_peak();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_sample_fifo.md
Name: adc_sample_fifo

Overview:
- Buffering stage directly downstream of the sigma-delta ADC decimator.
- Accepts one decimated sample per in_valid pulse; the source has no backpressure.
- Presents samples on a first-word-fall-through ready/valid stream for the consumer (DSP, bus bridge, UART packer).
- Flags loss of samples when the consumer stalls longer than the buffer can absorb.

Parameters:
- WIDTH, 16: sample width in bits; two's complement when the ADC output is signed.
- DEPTH, 16: FIFO capacity in samples; power of 2, minimum 2.
- AFULL_LEVEL, 12: almost_full threshold; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock, the same clock as the ADC.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- in_data  in  WIDTH  sample from the ADC output.
- in_valid  in  1  single-cycle strobe from the ADC valid; there is no ready back to the source.
- out_data  out  WIDTH  head-of-queue sample.
- out_valid  out  1  head sample present.
- out_ready  in  1  consumer accepts the head sample.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  high when level >= AFULL_LEVEL.
- overflow  out  1  sticky flag: at least one sample was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset:
  - Asserting rst low immediately forces out_valid=0, out_data=0, level=0, almost_full=0, overflow=0.
  - Read/write pointers are cleared to 0; memory contents are don't-care.
  - Reset mid-stream discards all queued samples.
  - Deassertion is synchronised externally; the first accepted write can occur on the first clk edge with rst high.
- Pop: occurs on a clk edge when out_valid && out_ready.
- Push:
  - Occurs on a clk edge when in_valid && (level < DEPTH || pop).
  - When full, a simultaneous pop frees the slot, so the write is accepted and level stays at DEPTH.
- Drop:
  - in_valid && level == DEPTH && !pop: the sample is discarded, the queue is unchanged, and overflow is set on that edge.
- Occupancy:
  - level is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
  - level never exceeds DEPTH and never underflows.
- FWFT output:
  - out_valid = (level != 0), registered.
  - out_data always equals the oldest unpopped sample.
  - Latency: in_valid at edge N into an empty FIFO gives out_valid=1 and out_data=sample after edge N.
  - The output must not glitch or change while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; pointers wrap modulo DEPTH without skipping entries.
- Pop on empty: out_ready while out_valid=0 is ignored.
- almost_full: registered, and updated on the same edge as level.
- overflow:
  - Cleared by ovf_clr on an edge.
  - If a drop and ovf_clr occur on the same edge, set wins and overflow=1.
- Width rule: no arithmetic on data; samples pass bit-exact.

Optional Feature:
- Macro: ADC_FIFO_PEAK_EN.
- With the macro defined:
  - Adds ports peak_abs (out, WIDTH-1) and peak_clr (in, 1).
  - On each accepted push, peak_abs updates to max(peak_abs, |in_data|), with in_data treated as signed.
  - |most negative| saturates to 2^(WIDTH-1)-1.
  - Dropped samples are not included.
  - peak_clr reloads peak_abs to 0. If peak_clr and a push occur on the same edge, peak_abs = |in_data| of that push.
  - peak_abs resets to 0 under rst.
- Without the macro: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Basic flow, out_ready=1: push 0x1234 then 0xABCD on non-adjacent cycles -> out_data shows 0x1234 one cycle after the first strobe, then 0xABCD; level returns to 0; overflow stays 0.
- Fill and drop, out_ready=0: push 17 samples 0..16 -> level=16; almost_full=1 after the 12th push; sample 16 dropped; overflow=1. Then drain -> out_data reads 0..15 in order.
- Full with simultaneous push and pop: at level=16, assert in_valid=0x5555 and out_ready on the same edge -> level stays 16, overflow stays 0, 0x5555 is read last.
- Overflow clear race: drop and ovf_clr on the same edge -> overflow=1; ovf_clr alone on the next edge -> overflow=0.
- Async reset mid-stream: with level=7, pull rst low between edges -> out_valid, level, almost_full and overflow are 0 immediately. After release, push 0x0042 -> out_data=0x0042.
- Peak detect (ADC_FIFO_PEAK_EN): push 0x0100, 0xFE00, 0x8000 -> peak_abs 0x0100, 0x0200, 0x7FFF. peak_clr together with a push of 0x0003 -> peak_abs=0x0003.
